// File: rtl/rr_mux_arbiter.sv
// N:1 registered output channel shared by N_REQ valid/ready requesters.
// A round-robin arbiter picks one requester per free output slot and drives the mux select.
module rr_mux_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned SRC_W = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [SRC_W-1:0]        out_src,
  input  logic                    out_ready
);

  logic [SRC_W-1:0]   ptr;
  logic               slot_free;
  logic [2*N_REQ-1:0] dbl_valid;
  logic [N_REQ-1:0]   rot_valid;
  logic               found;
  logic [SRC_W-1:0]   offset;
  logic [SRC_W:0]     sum;
  logic [SRC_W-1:0]   winner;
  logic [SRC_W-1:0]   next_ptr;
  logic [DATA_W-1:0]  win_data;
  logic               grant;

  assign slot_free = !out_valid || out_ready;

  // Rotate the valid vector so that index ptr lands at bit 0.
  assign dbl_valid = {req_valid, req_valid} >> ptr;
  assign rot_valid = dbl_valid[N_REQ-1:0];

  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot_valid[k]) begin
        found  = 1'b1;
        offset = SRC_W'(k);
      end
    end
  end

  // Map the rotated offset back to an absolute requester index.
  assign sum    = {1'b0, ptr} + {1'b0, offset};
  assign winner = (sum >= (SRC_W+1)'(N_REQ)) ? SRC_W'(sum - (SRC_W+1)'(N_REQ)) : SRC_W'(sum);
  assign next_ptr = (winner == SRC_W'(N_REQ - 1)) ? '0 : SRC_W'(winner + SRC_W'(1));

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == SRC_W'(i)) win_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign grant     = rst && slot_free && found;
  assign req_ready = grant ? (N_REQ'(1) << winner) : '0;

  // Output register and round-robin pointer; ptr moves only on a transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (slot_free) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_src   <= winner;
        ptr       <= next_ptr;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter (N_REQ=4, DATA_W=8).
// A reference round-robin model feeds a scoreboard of expected output words.
module tb_rr_mux_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_ready;
  logic [7:0]  d [4];

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] src;
  } item_t;

  item_t sb[$];
  int    n_checks;
  int    n_errors;
  int    model_ptr;
  bit    exp_valid;

  assign req_data = {d[3], d[2], d[1], d[0]};

  rr_mux_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbiter: first valid index at or after p, wrapping.
  function automatic logic [3:0] model_grant(input logic [3:0] v, input int p);
    logic [3:0] g;
    g = 4'b0;
    for (int k = 0; k < 4; k++) begin
      if (g == 4'b0 && v[(p + k) % 4]) g = 4'(1 << ((p + k) % 4));
    end
    return g;
  endfunction

  task automatic model_reset();
    sb.delete();
    exp_valid = 1'b0;
    model_ptr = 0;
  endtask

  // Called at a falling edge with inputs already driven; checks, updates model, advances one cycle.
  task automatic cycle();
    logic [3:0] g;
    bit         free;
    int         gi;
    item_t      it;
    #1;
    free = !exp_valid || out_ready;
    g = free ? model_grant(req_valid, model_ptr) : 4'b0;
    check("req_ready", 32'(req_ready), 32'(g));
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'(0), 32'(1));
      end else begin
        check("out_data", 32'(out_data), 32'(sb[0].data));
        check("out_src", 32'(out_src), 32'(sb[0].src));
        if (out_ready) void'(sb.pop_front());
      end
    end
    if (free) begin
      if (g != 4'b0) begin
        gi = 0;
        for (int i = 0; i < 4; i++) if (g[i]) gi = i;
        it.data = d[gi];
        it.src  = 2'(gi);
        sb.push_back(it);
        exp_valid = 1'b1;
        model_ptr = (gi + 1) % 4;
      end else begin
        exp_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    out_ready = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) d[i] = 8'hA0 + 8'(i);
    model_reset();

    // 1: reset holds everything quiet even with all requests valid
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_src", 32'(out_src), 32'h0);
    rst = 1'b1;
    #1;
    check("first_grant", 32'(req_ready), 32'h1);
    cycle();

    // 2: all valid, continuous accept -> rotating grants
    repeat (8) cycle();
    check("stream_valid", 32'(out_valid), 32'h1);

    // 3: back-pressure on a single requester
    req_valid = 4'b0010;
    d[1] = 8'h55;
    cycle();
    check("bp_load_data", 32'(out_data), 32'h55);
    check("bp_load_src", 32'(out_src), 32'h1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_hold_data", 32'(out_data), 32'h55);
      check("bp_hold_src", 32'(out_src), 32'h1);
      check("bp_hold_ready", 32'(req_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_regrant", 32'(req_ready), 32'h2);
    cycle();

    // 4: fairness and pointer wrap
    req_valid = 4'b1000;
    cycle();
    req_valid = 4'b1001;
    #1;
    check("wrap_grant0", 32'(req_ready), 32'h1);
    cycle();
    #1;
    check("wrap_grant3", 32'(req_ready), 32'h8);
    cycle();

    // 5: idle gap keeps data and pointer
    req_valid = 4'b0100;
    d[2] = 8'h7E;
    cycle();
    req_valid = 4'b0000;
    cycle();
    cycle();
    check("idle_valid", 32'(out_valid), 32'h0);
    check("idle_data", 32'(out_data), 32'h7E);
    req_valid = 4'b1010;
    #1;
    check("idle_ptr_grant", 32'(req_ready), 32'h8);
    cycle();

    // 6: asynchronous reset during a stall
    out_ready = 1'b0;
    req_valid = 4'b1111;
    cycle();
    check("stall_valid", 32'(out_valid), 32'h1);
    #2;
    rst = 1'b0;
    req_valid = 4'b0000;
    #1;
    check("async_out_valid", 32'(out_valid), 32'h0);
    check("async_ready", 32'(req_ready), 32'h0);
    model_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'b1010;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'h2);
    cycle();
    req_valid = 4'b0000;
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
